// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel enable, h/v counters, syncs, display-active
// flag and per-frame game ticks. Everything runs on clk; the pixel rate is a
// registered enable rather than a derived clock.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 783,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 514,
    parameter int FRAME_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick,
    output logic       game_tick,
    output logic       game_clk
);

    // Divider is at least one bit wide so CLK_DIV=1 still elaborates.
    localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]      H_SW     = 10'(H_SYNC);
    localparam logic [9:0]      V_SW     = 10'(V_SYNC);
    localparam logic [9:0]      H_AS     = 10'(H_ACT_START);
    localparam logic [9:0]      H_AE     = 10'(H_ACT_END);
    localparam logic [9:0]      V_AS     = 10'(V_ACT_START);
    localparam logic [9:0]      V_AE     = 10'(V_ACT_END);
    localparam logic [7:0]      FD_LAST  = 8'(FRAME_DIV - 1);

    logic [DW-1:0] r_div;
    logic          r_pix_en;
    logic [9:0]    r_hcount;
    logic [9:0]    r_vcount;
    logic          r_frame_tick;
    logic [7:0]    r_fcnt;
    logic          r_game_tick;
    logic          r_game_clk;

    logic w_line_end;
    logic w_frame_end;
    logic w_fcnt_wrap;

    // Last pixel of a line, qualified by the pixel enable.
    assign w_line_end  = r_pix_en && (r_hcount == H_LAST);
    assign w_frame_end = w_line_end && (r_vcount == V_LAST);
    assign w_fcnt_wrap = r_frame_tick && (r_fcnt == FD_LAST);

    // Clock divider and registered one-cycle pixel enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            r_pix_en <= (r_div == DIV_LAST);
        end
    end

    // Horizontal/vertical raster counters, advanced once per pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_pix_en) begin
            if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
        end
    end

    // Frame tick on the step into the first blanking line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_frame_tick <= 1'b0;
        else     r_frame_tick <= w_line_end && (r_vcount == V_AE);
    end

    // Frame counter divides frame ticks down to game ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt      <= '0;
            r_game_tick <= 1'b0;
        end else begin
            r_game_tick <= w_fcnt_wrap;
            if (r_frame_tick) r_fcnt <= (r_fcnt == FD_LAST) ? '0 : r_fcnt + 1'b1;
        end
    end

    // Slow renderer clock: rises with game_tick, falls at the frame wrap; set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_game_clk <= 1'b0;
        else if (w_fcnt_wrap) r_game_clk <= 1'b1;
        else if (w_frame_end) r_game_clk <= 1'b0;
    end

    assign pix_en     = r_pix_en;
    assign hCount     = r_hcount;
    assign vCount     = r_vcount;
    assign hSync      = (r_hcount >= H_SW);
    assign vSync      = (r_vcount >= V_SW);
    assign bright     = (r_hcount >= H_AS) && (r_hcount <= H_AE) &&
                        (r_vcount >= V_AS) && (r_vcount <= V_AE);
    assign frame_tick = r_frame_tick;
    assign game_tick  = r_game_tick;
    assign game_clk   = r_game_clk;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz raster timing that drives the game renderer: pixel-rate enable, horizontal/vertical counters, sync pulses, display-active flag and per-frame game ticks. It sits directly upstream of the block/obstacle renderer, which consumes `hCount`, `vCount` and `bright` combinationally and advances object positions on `game_clk`. All counters run on `clk` gated by an internal pixel enable, so the whole design stays in one clock domain.

## Interface
- `CLK_DIV`, 4, `clk` cycles per pixel (100 MHz -> 25 MHz); legal range 1..16
- `H_TOTAL`, 800, pixels per line
- `H_SYNC`, 96, hSync low width in pixels
- `H_ACT_START`, 144, first visible hCount
- `H_ACT_END`, 783, last visible hCount
- `V_TOTAL`, 525, lines per frame
- `V_SYNC`, 2, vSync low width in lines
- `V_ACT_START`, 35, first visible vCount
- `V_ACT_END`, 514, last visible vCount
- `FRAME_DIV`, 1, frames per game tick; legal range 1..255
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-high reset
- `pix_en` out 1: one-`clk` pulse, once per pixel
- `hCount` out 10: horizontal position, 0..H_TOTAL-1
- `vCount` out 10: vertical position, 0..V_TOTAL-1
- `hSync` out 1: active-low horizontal sync
- `vSync` out 1: active-low vertical sync
- `bright` out 1: high inside the visible 640x480 window
- `frame_tick` out 1: one-`clk` pulse at the start of vertical blanking
- `game_tick` out 1: one-`clk` pulse every FRAME_DIV frames
- `game_clk` out 1: registered slow clock for the renderer; rises with `game_tick`

## Operation
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_en` is registered and is high in the cycle after `div_cnt`==CLK_DIV-1. With CLK_DIV=1, `pix_en` is constantly high after the first post-reset cycle.
- `hCount` and `vCount` update only on cycles where `pix_en`=1.
  - `hCount`==H_TOTAL-1: `hCount` wraps to 0 and `vCount` advances.
  - Otherwise `hCount` increments by 1.
  - `vCount`==V_TOTAL-1 at a line wrap: `vCount` wraps to 0.
- Combinational decodes from the registered counters, so they are aligned with the counters in the same cycle:
  - `hSync` = !(`hCount` < H_SYNC)
  - `vSync` = !(`vCount` < V_SYNC)
  - `bright` = H_ACT_START<=`hCount`<=H_ACT_END && V_ACT_START<=`vCount`<=V_ACT_END
- `frame_tick` is registered. It is high for exactly one `clk` in the cycle after the `pix_en` cycle in which `hCount`==H_TOTAL-1 and `vCount`==V_ACT_END, which is the transition into the first blanking line.
- Frame counter `fcnt` (8 bit) updates on `frame_tick`:
  - `fcnt`==FRAME_DIV-1: `fcnt` wraps to 0 and `game_tick` pulses in the next cycle.
  - Otherwise `fcnt` increments.
- `game_clk` (registered):
  - Set to 1 in the same cycle `game_tick` is high.
  - Cleared to 0 on the `pix_en` cycle where `vCount` wraps V_TOTAL-1 -> 0.
  - Result: one glitch-free rising edge per game tick and a high time of about 10 lines.
- Reset, asynchronous, applied at any time including mid-line or mid-frame:
  - `div_cnt`, `hCount`, `vCount`, `fcnt` = 0
  - `pix_en`, `frame_tick`, `game_tick`, `game_clk` = 0
  - By decode: `hSync`=0, `vSync`=0, `bright`=0
  - Timing restarts from pixel (0,0) on the first `clk` after release. No partial frame_tick or game_tick may be emitted from pre-reset state.

## Timing
- First `pix_en` after reset release: cycle CLK_DIV. First `hCount` increment: cycle CLK_DIV+1.
- Line period: H_TOTAL*CLK_DIV `clk` cycles (3200). Frame period: H_TOTAL*V_TOTAL*CLK_DIV cycles (1,680,000).
- Visible corners: top-left (144,35), bottom-right (783,514). `bright` is high for exactly 640*480 pixels per frame.
- `frame_tick` to `game_tick` latency: 1 `clk` when `fcnt` wraps.
- `frame_tick` and a `vCount` wrap never coincide. `game_tick` set and `game_clk` clear never coincide for legal parameters. If they did, set wins.

## Test plan
- Reset held, then released: all outputs are 0 and `hSync`=`vSync`=0. First `pix_en` occurs at cycle 4 after release, and `hCount`=1 at cycle 5.
- Run one full line: `hSync` is low for `hCount` 0..95 and high from 96. `hCount` goes 799 -> 0 and `vCount` goes 0 -> 1 on the same `pix_en`.
- Run one full frame: `bright` is high for exactly 307,200 `pix_en` cycles. `bright` is first high at (144,35) and last high at (783,514). `vSync` is low for lines 0..1.
- FRAME_DIV=3, run 7 frames: 7 `frame_tick` pulses, each one `clk` wide and 1,680,000 cycles apart. `game_tick` occurs after frame_tick #3 and #6 only. `game_clk` shows 2 rising edges and falls at each `vCount` wrap.
- Assert `rst` mid-frame at (400,300) for 3 cycles: counters read 0 immediately, with no `frame_tick` or `game_tick` pulse. After release, the full-frame checks pass again from (0,0).
- CLK_DIV=1: `pix_en` is constantly high from cycle 1 after reset, and the line period is 800 cycles.
